// File: rtl/score_bcd_arbiter_pkg.sv
// Purpose: shared constants, FSM encoding and digit helper for the score BCD arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package score_bcd_arbiter_pkg;

    localparam int BIN_W      = 12;             // binary input width
    localparam int BCD_DIGITS = 4;              // BCD digits per result
    localparam int BCD_W      = 4 * BCD_DIGITS; // packed BCD result width
    localparam int STEP_COUNT = 12;             // shift-add-3 steps per conversion
    localparam int CNT_W      = 4;              // wide enough to count STEP_COUNT

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // A digit of 5 or more would overflow past 9 when doubled; pre-add 3 so
    // the following left shift carries correctly into the next digit.
    function automatic logic [3:0] add3_digit(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/score_bcd_arbiter_if.sv
// Purpose: request/ack/result bundle between two requesters and the BCD arbiter.
// Latency: n/a (wires only).
// Backpressure: req is held by the requester until ack; results are fire-and-forget pulses.
interface score_bcd_arbiter_if;
    import score_bcd_arbiter_pkg::*;

    logic             req0;
    logic             req1;
    logic [BIN_W-1:0] bin0;
    logic [BIN_W-1:0] bin1;
    logic             ack0;
    logic             ack1;
    logic             busy;
    logic             done0;
    logic             done1;
    logic [BCD_W-1:0] bcd0;
    logic [BCD_W-1:0] bcd1;

    modport master (
        output req0, req1, bin0, bin1,
        input  ack0, ack1, busy, done0, done1, bcd0, bcd1
    );

    modport slave (
        input  req0, req1, bin0, bin1,
        output ack0, ack1, busy, done0, done1, bcd0, bcd1
    );

endinterface

// File: rtl/bcd_shift_step.sv
// Purpose: one double-dabble step: add-3 on each of 4 digits, then shift in one serial bit.
// Latency: combinational.
// Backpressure: none.
module bcd_shift_step
    import score_bcd_arbiter_pkg::*;
(
    input  logic [BCD_W-1:0] dig_i,
    input  logic             bit_i,
    output logic [BCD_W-1:0] dig_o
);

    logic [BCD_W-1:0] adj;
    logic             unused_carry;

    // Correct every digit, then shift the whole digit vector left by one bit.
    always_comb begin
        adj = '0;
        for (int k = 0; k < BCD_DIGITS; k++) begin
            adj[4*k +: 4] = add3_digit(dig_i[4*k +: 4]);
        end
        dig_o = {adj[BCD_W-2:0], bit_i};
    end

    // The top digit never reaches 8 for 12-bit inputs, so the bit shifted out is always 0.
    assign unused_carry = adj[BCD_W-1];

endmodule

// File: rtl/score_bcd_arbiter.sv
// Purpose: round-robin arbiter for two requesters sharing one serial binary-to-BCD converter.
// Latency: ack in grant cycle T, doneN and new bcdN in T+13, next grant no earlier than T+14.
// Backpressure: requests wait (req held, no ack) while busy; no grants outside IDLE.
module score_bcd_arbiter
    import score_bcd_arbiter_pkg::*;
#(
    parameter int W    = BIN_W,      // only 12 is supported
    parameter int NDIG = BCD_DIGITS  // only 4 is supported
) (
    input  logic               clk,
    input  logic               reset,
    score_bcd_arbiter_if.slave bus
);

    localparam int DW = 4 * NDIG;

    state_t           state_q, state_d;
    logic             last_q, last_d;     // channel granted most recently (1 = ch1)
    logic             chan_q, chan_d;     // channel owning the in-flight conversion
    logic [W-1:0]     shreg_q, shreg_d;
    logic [DW-1:0]    dig_q, dig_d;
    logic [DW-1:0]    dig_step;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    bcd0_q, bcd0_d;
    logic [DW-1:0]    bcd1_q, bcd1_d;
    logic             grant_vld;
    logic             grant_ch;

    bcd_shift_step u_step (
        .dig_i (dig_q),
        .bit_i (shreg_q[W-1]),
        .dig_o (dig_step)
    );

    // Round-robin pick: on a tie the channel not granted last wins.
    always_comb begin
        grant_vld = bus.req0 | bus.req1;
        if (bus.req0 && bus.req1) begin
            grant_ch = ~last_q;
        end else begin
            grant_ch = bus.req1;
        end
    end

    // Next-state and datapath updates for the IDLE -> SHIFT x12 -> DONE sequence.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        chan_d  = chan_q;
        shreg_d = shreg_q;
        dig_d   = dig_q;
        cnt_d   = cnt_q;
        bcd0_d  = bcd0_q;
        bcd1_d  = bcd1_q;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    state_d = ST_SHIFT;
                    last_d  = grant_ch;
                    chan_d  = grant_ch;
                    shreg_d = grant_ch ? bus.bin1 : bus.bin0;
                    dig_d   = '0;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                shreg_d = {shreg_q[W-2:0], 1'b0};
                dig_d   = dig_step;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(STEP_COUNT - 1)) begin
                    state_d = ST_DONE;
                    if (chan_q) begin
                        bcd1_d = dig_step;
                    end else begin
                        bcd0_d = dig_step;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake and status outputs; reset masks them so a request seen during reset is not acked.
    always_comb begin
        bus.ack0  = 1'b0;
        bus.ack1  = 1'b0;
        bus.done0 = 1'b0;
        bus.done1 = 1'b0;
        bus.busy  = 1'b0;
        if (!reset) begin
            bus.ack0  = (state_q == ST_IDLE) && grant_vld && !grant_ch;
            bus.ack1  = (state_q == ST_IDLE) && grant_vld &&  grant_ch;
            bus.done0 = (state_q == ST_DONE) && !chan_q;
            bus.done1 = (state_q == ST_DONE) &&  chan_q;
            bus.busy  = (state_q != ST_IDLE);
        end
    end

    assign bus.bcd0 = bcd0_q;
    assign bus.bcd1 = bcd1_q;

    // State register; reset discards any in-flight conversion and leaves ch0 first in line.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            chan_q  <= 1'b0;
            shreg_q <= '0;
            dig_q   <= '0;
            cnt_q   <= '0;
            bcd0_q  <= '0;
            bcd1_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            chan_q  <= chan_d;
            shreg_q <= shreg_d;
            dig_q   <= dig_d;
            cnt_q   <= cnt_d;
            bcd0_q  <= bcd0_d;
            bcd1_q  <= bcd1_d;
        end
    end

endmodule

// File: tb/tb_score_bcd_arbiter.sv
// Purpose: self-checking bench for score_bcd_arbiter (vector table, corner sequences, full sweep).
// Latency: expects ack at grant cycle T and done at T+13.
// Backpressure: requesters hold req until ack, then drop it and scramble bin.
module tb_score_bcd_arbiter;
    import score_bcd_arbiter_pkg::*;

    typedef struct {
        int          ch;
        int          bin;
        int          bin_after;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        int          ch;
        logic [15:0] bcd;
    } sb_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    score_bcd_arbiter_if bus();

    score_bcd_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          grant_cyc = -1;
    int          grant_ch_seen = -1;
    sb_t         sb_q[$];
    int          glog_cyc[$];
    int          glog_ch[$];
    logic [15:0] shadow0 = '0;
    logic [15:0] shadow1 = '0;
    int          n_ack0 = 0, n_ack1 = 0, n_done0 = 0, n_done1 = 0;
    int          exp_ack0 = 0, exp_ack1 = 0;
    vec_t        tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Watches every cycle: grant log, done latency, scoreboard pops, untouched channel.
    task automatic monitor();
        int  ch;
        sb_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                shadow0   = '0;
                shadow1   = '0;
                grant_cyc = -1;
            end else begin
                if (bus.ack0 || bus.ack1) begin
                    check("ack_exclusive", 32'(bus.ack0 & bus.ack1), 0);
                    grant_cyc     = cyc;
                    grant_ch_seen = bus.ack1 ? 1 : 0;
                    glog_cyc.push_back(cyc);
                    glog_ch.push_back(grant_ch_seen);
                    if (bus.ack0) n_ack0++; else n_ack1++;
                end
                if (bus.done0 || bus.done1) begin
                    ch = bus.done1 ? 1 : 0;
                    check("done_exclusive", 32'(bus.done0 & bus.done1), 0);
                    check("done_latency", cyc - grant_cyc, 13);
                    check("done_chan", ch, grant_ch_seen);
                    check("sb_nonempty", 32'(sb_q.size() > 0), 1);
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        check("sb_chan", ch, e.ch);
                        check("sb_bcd", ch ? bus.bcd1 : bus.bcd0, e.bcd);
                        check("other_bcd_kept", ch ? bus.bcd0 : bus.bcd1, ch ? shadow0 : shadow1);
                        if (ch == 1) shadow1 = e.bcd; else shadow0 = e.bcd;
                    end
                    if (ch == 1) n_done1++; else n_done0++;
                end
            end
        end
    endtask

    // One request from a single channel; called at posedge+1, returns at posedge+1 of the IDLE cycle.
    task automatic convert(input int ch, input int val, input int after, input logic [15:0] exp);
        bit got;
        sb_q.push_back('{ch, exp});
        if (ch == 0) begin bus.req0 = 1'b1; bus.bin0 = 12'(val); exp_ack0++; end
        else         begin bus.req1 = 1'b1; bus.bin1 = 12'(val); exp_ack1++; end
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((ch == 0) ? bus.ack0 : bus.ack1) begin got = 1'b1; break; end
        end
        check("ack_seen", 32'(got), 1);
        @(posedge clk); #1;
        if (ch == 0) begin bus.req0 = 1'b0; bus.bin0 = 12'(after); end
        else         begin bus.req1 = 1'b0; bus.bin1 = 12'(after); end
        if (got) begin
            got = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if ((ch == 0) ? bus.done0 : bus.done1) begin got = 1'b1; break; end
            end
            check("done_seen", 32'(got), 1);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int rel;
        int d0;
        int a1;
        bit got;

        tbl[0] = '{0, 4095,    0, 16'h4095};
        tbl[1] = '{1,    0, 1234, 16'h0000};
        tbl[2] = '{1,  999,    0, 16'h0999};
        tbl[3] = '{0,  250,  777, 16'h0250};
        tbl[4] = '{0, 1234, 4095, 16'h1234};
        tbl[5] = '{1, 4000,    1, 16'h4000};
        tbl[6] = '{0,    5,    9, 16'h0005};
        tbl[7] = '{1,   59, 4095, 16'h0059};
        tbl[8] = '{0, 1000,    0, 16'h1000};
        tbl[9] = '{1, 3210, 2222, 16'h3210};

        reset    = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.bin0 = '0;
        bus.bin1 = '0;
        fork monitor(); join_none

        // Reset state, with requests raised to confirm reset beats them.
        repeat (3) @(posedge clk);
        #1;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        @(negedge clk);
        check("rst_ack0", 32'(bus.ack0), 0);
        check("rst_ack1", 32'(bus.ack1), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done0", 32'(bus.done0), 0);
        check("rst_done1", 32'(bus.done1), 0);
        check("rst_bcd0", 32'(bus.bcd0), 0);
        check("rst_bcd1", 32'(bus.bcd1), 0);
        @(posedge clk); #1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(bus.busy), 0);
        @(posedge clk); #1;

        // Vector table: value, late bin change, expected packed BCD.
        for (int i = 0; i < 10; i++) begin
            convert(tbl[i].ch, tbl[i].bin, tbl[i].bin_after, tbl[i].exp);
            check("tbl_bcd", (tbl[i].ch == 1) ? bus.bcd1 : bus.bcd0, tbl[i].exp);
        end

        // ch1 raises and drops req while ch0 is converting: never acked.
        a1 = n_ack1;
        fork
            convert(0, 321, 0, 16'h0321);
            begin
                repeat (3) @(posedge clk);
                #2 bus.req1 = 1'b1;
                repeat (4) @(posedge clk);
                #2 bus.req1 = 1'b0;
            end
        join
        repeat (5) @(posedge clk);
        #1;
        check("dropped_req_no_ack", n_ack1, a1);

        // Both requesting from reset release: ch0, ch1, ch0, ch1, 14 cycles apart.
        reset = 1'b1;
        @(posedge clk); #1;
        bus.bin0 = 12'd11;
        bus.bin1 = 12'd22;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        @(posedge clk); #1;
        glog_cyc.delete();
        glog_ch.delete();
        sb_q.push_back('{0, 16'h0011});
        sb_q.push_back('{1, 16'h0022});
        sb_q.push_back('{0, 16'h0011});
        sb_q.push_back('{1, 16'h0022});
        exp_ack0 += 2;
        exp_ack1 += 2;
        rel   = cyc;
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (glog_cyc.size() >= 4) break;
        end
        @(posedge clk); #1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0) begin got = 1'b1; break; end
        end
        check("rr_all_done", 32'(got), 1);
        check("rr_grant_count", glog_cyc.size(), 4);
        if (glog_cyc.size() >= 4) begin
            check("rr_first_grant_cycle", glog_cyc[0], rel + 1);
            for (int k = 0; k < 4; k++) begin
                check("rr_order", glog_ch[k], k % 2);
                if (k > 0) check("rr_spacing", glog_cyc[k] - glog_cyc[k-1], 14);
            end
        end
        @(posedge clk); #1;

        // Reset in the 6th SHIFT cycle of a ch0 conversion discards it.
        bus.req0 = 1'b1;
        bus.bin0 = 12'd1234;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.ack0) begin got = 1'b1; break; end
        end
        check("abort_ack", 32'(got), 1);
        exp_ack0++;
        @(posedge clk); #1;
        bus.req0 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        check("abort_busy_mid", 32'(bus.busy), 1);
        @(posedge clk); #1;
        reset = 1'b1;
        d0    = n_done0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_bcd0", 32'(bus.bcd0), 0);
        repeat (20) @(negedge clk);
        check("abort_no_done0", n_done0, d0);
        @(posedge clk); #1;

        // Exhaustive sweep of ch0 against the decimal model.
        for (int v = 0; v < 4096; v++) begin
            convert(0, v, int'($urandom_range(0, 4095)), to_bcd(v));
        end

        check("total_ack0", n_ack0, exp_ack0);
        check("total_ack1", n_ack1, exp_ack1);
        check("total_done0", n_done0, exp_ack0 - 1);
        check("total_done1", n_done1, exp_ack1);
        check("sb_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/score_bcd_arbiter.md
SCORE_BCD_ARBITER -- requirements
Module: score_bcd_arbiter

Interface
REQ-001 Parameter: W, 12, binary input width; only 12 is supported.
REQ-002 Parameter: NDIG, 4, BCD digits per result; only 4 is supported.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: req0 / req1  input  1 each  conversion request, held high by the requester until its ack.
REQ-006 Port: bin0 / bin1  input  12 each  unsigned binary value, sampled only on the grant edge.
REQ-007 Port: ack0 / ack1  output  1 each  high for exactly the grant cycle; bin sampled on that edge.
REQ-008 Port: busy  output  1  high whenever state is not IDLE.
REQ-009 Port: done0 / done1  output  1 each  one-cycle pulse when that channel's result updates.
REQ-010 Port: bcd0 / bcd1  output  16 each  packed BCD result, thousands digit in [15:12] down to ones digit in [3:0]; holds value between updates.

Function
REQ-011 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-012 IDLE: no req -> stay; any req -> grant one channel, assert its ack combinationally that cycle, load shift reg = binN, digits = 0, step count = 0, state -> SHIFT.
REQ-013 Arbitration SHALL be round-robin: both req -> grant the channel not granted last; single req -> grant it regardless; last-grant pointer updates on every grant.
REQ-014 SHIFT: per cycle, each digit >= 5 gets +3, then {digits, shift reg} shift left 1; exactly 12 SHIFT cycles, then -> DONE.
REQ-015 Result SHALL be written to bcdN of the granted channel on the edge ending the 12th SHIFT cycle; the other channel's bcd is untouched.
REQ-016 DONE: doneN high for one cycle, state -> IDLE; no grant in DONE.
REQ-017 Latency: grant in cycle T -> doneN and new bcdN visible in cycle T+13; earliest next grant T+14.
REQ-018 Digit arithmetic SHALL be 4-bit per digit; full range 0..4095 converts exactly, no saturation.
REQ-019 Changes on binN or reqN after the grant edge SHALL NOT affect the in-flight conversion.
REQ-020 req dropped before ack SHALL produce no ack, no done, no state change.
REQ-021 ack and done SHALL never be high for both channels in the same cycle.

Reset
REQ-022 reset SHALL force state IDLE, bcd0 = bcd1 = 0, shift reg / digits / step count = 0, last-grant pointer = channel 1 (so channel 0 wins first tie), ack/done/busy = 0.
REQ-023 reset during SHIFT or DONE SHALL discard the conversion with no done pulse; reset takes priority over any simultaneous req.

Structure
REQ-024 Shared package SHALL hold the state encoding, W, NDIG, and step count constant (12).
REQ-025 One combinational sub-module bcd_shift_step SHALL implement one add-3-then-shift step over 4 digits plus 1 serial input bit; the FSM instantiates it once.

Verification
REQ-026 Reset, req0 with bin0 = 4095 -> ack0 in cycle 0, done0 in cycle 13, bcd0 = 16'h4095, bcd1 = 0.
REQ-027 req1 with bin1 = 0, then 999 -> bcd1 = 16'h0000, then 16'h0999; done1 pulses once each, done0 never.
REQ-028 req0 and req1 both held from reset release -> grants ch0, ch1, ch0, ch1 in order, each done 13 cycles after its ack, grants 14 cycles apart.
REQ-029 reset asserted in the 6th SHIFT cycle of a ch0 conversion of 1234 -> busy 0 next cycle, no done0, bcd0 = 0.
REQ-030 bin0 = 250 at grant, changed to 777 the next cycle -> bcd0 = 16'h0250.
REQ-031 Sweep bin0 over 0..4095 -> every bcd0 matches the golden decimal model.
